// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Purpose
//   Decodes the immediate field of an RV32 instruction word and queues the
//   result in a small FIFO with a valid/ready handshake on both sides.
//   Each decoded entry holds the sign-extended immediate, its format code and,
//   optionally, an illegal-opcode flag. An instruction accepted into an empty
//   buffer is visible on the outputs one cycle later. All outputs come from
//   registered state; the only combinational input-to-output path is
//   iReady -> oReady, so a full buffer can accept in the same cycle it pops.
//
// Parameters
//   XLEN   immediate width, 32 or 64
//   DEPTH  number of buffer entries, 1..4
//
// Ports
//   iCLK        in   1             clock, all state changes on the rising edge
//   iRST        in   1             synchronous active-high reset
//   iValid      in   1             iInstrucao holds a valid instruction
//   oReady      out  1             an instruction is accepted this cycle
//   iInstrucao  in   32            RV32 instruction word
//   iFlush      in   1             drop all buffered and incoming entries
//   oValid      out  1             head entry valid
//   iReady      in   1             consumer takes the head entry
//   oImm        out  XLEN          head entry immediate (sign-extended)
//   oFmt        out  3             head format: 0 NONE,1 I,2 S,3 B,4 U,5 J
//   oIllegal    out  1             head entry has an unsupported opcode
//   oOcc        out  clog2(DEPTH+1) number of buffered entries
//
// Configuration
//   IMM_GEN_ILLEGAL_EN  when defined, entries whose format is NONE or whose
//                       inst[1:0] != 2'b11 are flagged on oIllegal and carry
//                       a zero immediate and format. When undefined, oIllegal
//                       is tied low and no flag storage is built.
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                         iCLK,
   input  logic                         iRST,
   input  logic                         iValid,
   output logic                         oReady,
   input  logic [31:0]                  iInstrucao,
   input  logic                         iFlush,
   output logic                         oValid,
   input  logic                         iReady,
   output logic [XLEN-1:0]              oImm,
   output logic [2:0]                   oFmt,
   output logic                         oIllegal,
   output logic [$clog2(DEPTH+1)-1:0]   oOcc
);

   // Pointer width; a single-entry buffer still needs a 1-bit pointer.
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = $clog2(DEPTH + 1);

   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

   // Format codes presented on oFmt.
   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;

   // Opcodes that carry an immediate.
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // -------------------------------------------------------------------------
   // Decode of the incoming word (feeds only the buffer write port)
   // -------------------------------------------------------------------------
   logic [31:0]      imm32;
   logic [XLEN-1:0]  dec_imm;
   logic [2:0]       dec_fmt;
`ifdef IMM_GEN_ILLEGAL_EN
   logic             dec_ill;
`endif

   always_comb begin
      imm32   = '0;
      dec_fmt = FMT_NONE;
      dec_imm = '0;
`ifdef IMM_GEN_ILLEGAL_EN
      dec_ill = 1'b0;
`endif
      case (iInstrucao[6:0])
         OP_LOAD, OP_IMM, OP_JALR: begin
            dec_fmt = FMT_I;
            imm32   = {{20{iInstrucao[31]}}, iInstrucao[31:20]};
         end
         OP_STORE: begin
            dec_fmt = FMT_S;
            imm32   = {{20{iInstrucao[31]}}, iInstrucao[31:25], iInstrucao[11:7]};
         end
         OP_BRANCH: begin
            dec_fmt = FMT_B;
            imm32   = {{19{iInstrucao[31]}}, iInstrucao[31], iInstrucao[7],
                       iInstrucao[30:25], iInstrucao[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            dec_fmt = FMT_U;
            imm32   = {iInstrucao[31:12], 12'b0};
         end
         OP_JAL: begin
            dec_fmt = FMT_J;
            imm32   = {{11{iInstrucao[31]}}, iInstrucao[31], iInstrucao[19:12],
                       iInstrucao[20], iInstrucao[30:21], 1'b0};
         end
         default: begin
            dec_fmt = FMT_NONE;
            imm32   = '0;
         end
      endcase

      // Every 32-bit immediate already has inst[31] in bit 31; widening to
      // XLEN just continues that sign. NONE stays all-zero.
      if (dec_fmt != FMT_NONE) begin
         dec_imm       = {XLEN{iInstrucao[31]}};
         dec_imm[31:0] = imm32;
      end

`ifdef IMM_GEN_ILLEGAL_EN
      // A non-11 low pair cannot match any opcode above, so it is already
      // NONE; it is listed explicitly to keep the intent obvious.
      dec_ill = (dec_fmt == FMT_NONE) || (iInstrucao[1:0] != 2'b11);
      if (dec_ill) begin
         dec_imm = '0;
         dec_fmt = FMT_NONE;
      end
`endif
   end

   // -------------------------------------------------------------------------
   // Buffer control
   // -------------------------------------------------------------------------
   logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [OW-1:0]    occ_reg, occ_next;
   logic             head_valid;
   logic             pop;
   logic             accept;
   logic [DEPTH-1:0] wr_en;

   assign head_valid = (occ_reg != '0);

   // A full buffer still takes a new word when the head leaves this cycle.
   assign oReady = (occ_reg < FULL_OCC) || ((occ_reg == FULL_OCC) && iReady);

   // Flush voids both sides of the handshake in its cycle.
   assign pop    = head_valid && iReady && !iFlush;
   assign accept = iValid && oReady && !iFlush;

   // One write strobe per slot, selected by the tail pointer.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_wr_en
         assign wr_en[gi] = accept && (wr_ptr_reg == PW'(gi));
      end
   endgenerate

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      // Pointers wrap modulo DEPTH, which need not be a power of two.
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      occ_next    = occ_reg;
      if (iFlush) begin
         rd_ptr_next = '0;
         wr_ptr_next = '0;
         occ_next    = '0;
      end else begin
         if (accept) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
         end
         if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
         end
         case ({accept, pop})
            2'b10:   occ_next = occ_reg + 1'b1;
            2'b01:   occ_next = occ_reg - 1'b1;
            default: occ_next = occ_reg;
         endcase
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
         occ_reg    <= occ_next;
      end
   end

   // -------------------------------------------------------------------------
   // Entry storage. Contents need no reset: the outputs are forced to zero
   // whenever the buffer is empty, and a slot is always written before it
   // becomes the head.
   // -------------------------------------------------------------------------
   logic [XLEN-1:0] imm_mem [DEPTH];
   logic [2:0]      fmt_mem [DEPTH];

   always_ff @(posedge iCLK) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en[i]) begin
            imm_mem[i] <= dec_imm;
            fmt_mem[i] <= dec_fmt;
         end
      end
   end

`ifdef IMM_GEN_ILLEGAL_EN
   logic ill_mem [DEPTH];

   always_ff @(posedge iCLK) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en[i]) begin
            ill_mem[i] <= dec_ill;
         end
      end
   end

   assign oIllegal = head_valid ? ill_mem[rd_ptr_reg] : 1'b0;
`else
   assign oIllegal = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Head presentation
   // -------------------------------------------------------------------------
   assign oValid = head_valid;
   assign oImm   = head_valid ? imm_mem[rd_ptr_reg] : '0;
   assign oFmt   = head_valid ? fmt_mem[rd_ptr_reg] : FMT_NONE;
   assign oOcc   = occ_reg;

endmodule
